// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core load/store port. It accepts one request at
//   a time, waits WAIT_CYCLES cycles, then performs a byte, half or word access on
//   an internal little-endian RAM of DEPTH 32-bit words. Misaligned accesses,
//   illegal funct3 values and out-of-range addresses return an error and leave the
//   RAM unchanged. Load data is sign- or zero-extended according to funct3.
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (RAM contents are kept)
//   req_valid   request present          req_ready  responder can accept
//   req_write   1 = store, 0 = load      req_funct3 RV32I load/store funct3
//   req_addr    byte address             req_wdata  store data (low bytes for SB/SH)
//   rsp_valid   response present         rsp_ready  requester takes the response
//   rsp_rdata   extended load data, 0 for stores and errors
//   rsp_err     request rejected
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req_ready_s;
  logic          rsp_valid_s;
  logic          accept_s;
  logic          mem_we_s;
  logic          err_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   word_s;
  logic [3:0]    mask_s;
  logic [31:0]   lanes_s;

  // Any reason to reject the captured request: bad funct3, misalignment, range.
  function automatic logic access_error(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    if (wr) begin
      bad_f3 = (f3 > 3'd2);
    end else begin
      bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    misaligned   = ((f3[1:0] == 2'd1) && addr[0]) ||
                   ((f3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH));
    return bad_f3 || misaligned || out_of_range;
  endfunction

  // Pick the addressed byte/half out of the word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] a,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    // Halves are aligned here, so shifting by a*8 lands on the right half too.
    sh = word >> {a, 3'b000};
    case (f3)
      3'd0:    res = {{24{sh[7]}}, sh[7:0]};
      3'd1:    res = {{16{sh[15]}}, sh[15:0]};
      3'd2:    res = word;
      3'd4:    res = {24'h000000, sh[7:0]};
      3'd5:    res = {16'h0000, sh[15:0]};
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  // Byte-enable mask for a store.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'd0:    m = 4'b0001 << a;
      2'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the store data so every lane sees the bytes it may receive.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] l;
    case (f3[1:0])
      2'd0:    l = {4{wd[7:0]}};
      2'd1:    l = {2{wd[15:0]}};
      default: l = wd;
    endcase
    return l;
  endfunction

  assign idx_s   = addr_q[AW+1:2];
  assign word_s  = mem_q[idx_s];
  assign err_s   = access_error(write_q, funct3_q, addr_q);
  assign mask_s  = store_mask(funct3_q, addr_q[1:0]);
  assign lanes_s = store_lanes(funct3_q, wdata_q);

  // State, wait counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h00000000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture; fields only load while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'h00000000;
      wdata_q  <= 32'h00000000;
    end else if (accept_s) begin
      write_q  <= req_write;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(CNT_INIT);
          end else begin
            state_d = S_ACCESS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state outputs, RAM write strobe and response register updates.
  always_comb begin
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    accept_s    = 1'b0;
    mem_we_s    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        req_ready_s = 1'b1;
        accept_s    = req_valid;
      end
      S_WAIT: begin
        req_ready_s = 1'b0;
      end
      S_ACCESS: begin
        err_d    = err_s;
        mem_we_s = write_q && !err_s;
        if (err_s || write_q) begin
          rdata_d = 32'h00000000;
        end else begin
          rdata_d = load_extract(funct3_q, addr_q[1:0], word_s);
        end
      end
      S_RESP: begin
        rsp_valid_s = 1'b1;
        // Clear on the handshake edge so idle outputs read as zero.
        if (rsp_ready) begin
          rdata_d = 32'h00000000;
          err_d   = 1'b0;
        end else begin
          rdata_d = rdata_q;
          err_d   = err_q;
        end
      end
      default: begin
        rdata_d = 32'h00000000;
        err_d   = 1'b0;
      end
    endcase
  end

  // RAM write port; intentionally unreset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= lanes_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_s;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Drives two responder instances (WAIT_CYCLES=2 and WAIT_CYCLES=0) through
//   directed and random load/store traffic and compares each response with a
//   byte-addressed reference memory kept in the bench.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_mem [longint];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  assign req_ready = sel ? b_req_ready : a_req_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (dut%0d): got 0x%08h expected 0x%08h", tag, sel, obs, exp);
    end
  endtask

  // Reference behaviour: byte memory per instance, rules straight from the ISA.
  function automatic void model_txn(input logic wr, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic err, output logic [31:0] rd);
    int     size;
    longint key;
    logic [63:0] v;
    size = 1 << f3[1:0];
    key  = (longint'(sel) << 32) + longint'(addr);
    err  = 1'b0;
    rd   = 32'h0;
    if (wr && f3 > 3'd2) err = 1'b1;
    if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1'b1;
    if (!err && (addr % size) != 0) err = 1'b1;
    if ((addr >> 2) >= DEPTH) err = 1'b1;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < size; i++) ref_mem[key + i] = 8'(wd >> (8 * i));
    end else begin
      v = 64'h0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[key + i]) << (8 * i));
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (~64'h0 << (8 * size));
      rd = v[31:0];
    end
  endfunction

  task automatic wait_rdy();
    int c = 0;
    while (!req_ready && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One full transaction; optionally stall the response for `hold` cycles.
  task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          c;
    model_txn(wr, f3, addr, wd, exp_er, exp_rd);
    wait_rdy();
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    c = 0;
    while (!rsp_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("latency", 32'(c), sel ? 32'd1 : 32'd3);
    rd = rsp_rdata;
    er = rsp_err;
    chk("rdata", rd, exp_rd);
    chk("err", 32'(er), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = addr;
      req_wdata  = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", 32'(rsp_err), 32'(er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'd0);
  endtask

  // Store accepted, then reset before it can commit; the model is left untouched.
  task automatic rst_mid(input logic [31:0] addr, input logic [31:0] wd);
    wait_rdy();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic random_ops(input int n, input int nwords);
    logic [31:0] rd, addr;
    logic        er, wr;
    logic [2:0]  f3;
    for (int k = 0; k < n; k++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        addr = ($urandom_range(0, 1) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 255)) : $urandom;
      end else begin
        addr = 32'($urandom_range(0, nwords * 4 - 1));
      end
      run(wr, f3, addr, $urandom, 0, rd, er);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rdata", rsp_rdata, 32'd0);
      chk("reset_err", 32'(rsp_err), 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 64; w++) run(1'b1, 3'd2, 32'(4 * w), $urandom, 0, rd, er);

    run(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
    run(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    chk("t1_lw", rd, 32'hDEADBEEF);

    run(1'b1, 3'd2, 32'h20, 32'h11223344, 0, rd, er);
    run(1'b1, 3'd0, 32'h21, 32'hAAAAAA80, 0, rd, er);
    run(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
    chk("t2_lw", rd, 32'h11228044);
    run(1'b0, 3'd0, 32'h21, 32'h0, 0, rd, er);
    chk("t2_lb", rd, 32'hFFFFFF80);
    run(1'b0, 3'd4, 32'h21, 32'h0, 0, rd, er);
    chk("t2_lbu", rd, 32'h00000080);

    run(1'b1, 3'd1, 32'h32, 32'h1234BEEF, 0, rd, er);
    run(1'b0, 3'd1, 32'h32, 32'h0, 0, rd, er);
    chk("t3_lh", rd, 32'hFFFFBEEF);
    run(1'b0, 3'd5, 32'h32, 32'h0, 0, rd, er);
    chk("t3_lhu", rd, 32'h0000BEEF);
    run(1'b0, 3'd1, 32'h31, 32'h0, 0, rd, er);
    chk("t3_mis_err", 32'(er), 32'd1);
    run(1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er);

    run(1'b1, 3'd2, 32'(4 * DEPTH), 32'h55AA55AA, 0, rd, er);
    chk("t4_range_err", 32'(er), 32'd1);
    run(1'b0, 3'd2, 32'h0, 32'h0, 0, rd, er);
    run(1'b0, 3'd3, 32'h0, 32'h0, 0, rd, er);
    chk("t4_f3_err", 32'(er), 32'd1);

    run(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er);
    run(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    chk("t5_no_side_effect", rd, 32'hDEADBEEF);

    run(1'b1, 3'd2, 32'h40, 32'h0, 0, rd, er);
    rst_mid(32'h40, 32'hCAFEF00D);
    run(1'b0, 3'd2, 32'h40, 32'h0, 0, rd, er);
    chk("t6_discard", rd, 32'h0);

    random_ops(300, 64);

    sel = 1'b1;
    for (int w = 0; w < 17; w++) run(1'b1, 3'd2, 32'(4 * w), $urandom, 0, rd, er);
    run(1'b1, 3'd2, 32'h40, 32'h0, 0, rd, er);
    rst_mid(32'h40, 32'hCAFEF00D);
    run(1'b0, 3'd2, 32'h40, 32'h0, 0, rd, er);
    chk("t6_w0_discard", rd, 32'h0);
    random_ops(100, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
